// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// FSM state constants, grant owner encoding and parameter defaults.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_MAX_DM_BURST   = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_BUSY_IF = 2'd1;
  localparam arb_state_t ST_BUSY_DM = 2'd2;
  localparam arb_state_t ST_ERR     = 2'd3;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  function automatic arb_state_t busy_state(input arb_owner_t own);
    return (own == OWN_IF) ? ST_BUSY_IF : ST_BUSY_DM;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Busy-cycle watchdog for mem_port_arbiter; only instantiated with ARB_TIMEOUT_EN.
// expired is high in the busy cycle that completes TIMEOUT_CYCLES without an ack.
module arb_timeout_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (busy && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = busy && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage requests onto one shared memory port.
// Optional busy watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned MAX_DM_BURST   = DEF_MAX_DM_BURST,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  localparam int unsigned BURST_W = $clog2(MAX_DM_BURST + 1);

  arb_state_t         state;
  arb_owner_t         grant_own;
  logic [BURST_W-1:0] burst_cnt;
  logic               if_killed;
  logic               dm_elig, if_elig, burst_limit;
  logic               grant_dm, grant_if, timeout;

  // A requester whose done is high this cycle is not regranted.
  assign dm_elig     = dm_req & ~dm_done;
  assign if_elig     = if_req & ~if_done & ~if_kill;
  assign burst_limit = burst_cnt >= BURST_W'(MAX_DM_BURST);

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_comb begin
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    grant_own = OWN_DM;
    if (state == ST_IDLE) begin
      if (dm_elig && !(if_elig && burst_limit)) begin
        grant_dm = 1'b1;
      end else if (if_elig) begin
        grant_if  = 1'b1;
        grant_own = OWN_IF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_killed <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_dm || grant_if) begin
            state     <= busy_state(grant_own);
            mem_req   <= 1'b1;
            mem_we    <= grant_dm & dm_we;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            if_killed <= 1'b0;
            if (grant_dm) mem_wdata <= dm_wdata;
          end
        end
        ST_BUSY_IF, ST_BUSY_DM: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == ST_BUSY_IF) begin
              // A kill seen earlier in the access or on the ack cycle drops the fetch.
              if (!if_killed && !if_kill) begin
                if_done  <= 1'b1;
                if_rdata <= mem_rdata;
              end
            end else begin
              dm_done <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end
          end else if (timeout) begin
            state   <= ST_ERR;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if ((state == ST_BUSY_IF) && if_kill) begin
            if_killed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Consecutive data grants made while a fetch is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!if_req || grant_if) begin
        burst_cnt <= '0;
      end else if (grant_dm && !burst_limit) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic busy, expired;

  assign busy = (state == ST_BUSY_IF) || (state == ST_BUSY_DM);

  arb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .start  (grant_dm | grant_if),
    .busy   (busy),
    .expired(expired)
  );

  assign timeout = expired & ~mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_err <= 1'b0;
    end else if (timeout) begin
      arb_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
  assign arb_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reference model, per-cycle compare, directed scenarios.
// Define ARB_TIMEOUT_EN to also run the watchdog scenario.
module tb_mem_port_arbiter;

  localparam int TO = 8;
  localparam int MAXB = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        if_done, if_stall, dm_done, dm_stall, mem_req, mem_we, arb_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_BURST(MAXB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay extra busy cycles, logs each new access.
  int          ack_delay = 0;
  bit          no_ack = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] glog[$];
  int          gcyc[$];

  initial forever begin
    @(negedge clk or posedge reset);
    if (reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        glog.push_back(mem_addr);
        gcyc.push_back(cyc);
      end
      if (!no_ack && wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hC0DE_0000 ^ mem_addr;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
      end
      wait_cnt++;
    end else begin
      mem_ack   = 1'b0;
      wait_cnt  = 0;
      mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
    end
  end

  // Reference model: who owns the port (0 none, 1 fetch, 2 data, 3 error).
  int          own = 0, streak = 0, busy_n = 0;
  bit          kill_seen = 1'b0, dm_ok, if_ok;
  logic        m_req = 0, m_we = 0, m_if_done = 0, m_dm_done = 0, m_err = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      own = 0; streak = 0; busy_n = 0; kill_seen = 1'b0;
      m_req = 0; m_we = 0; m_if_done = 0; m_dm_done = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    end else begin
      dm_ok = dm_req && !m_dm_done;
      if_ok = if_req && !m_if_done && !if_kill;
      m_if_done = 1'b0;
      m_dm_done = 1'b0;
      if (own == 0) begin
        if (dm_ok && !(if_ok && streak >= MAXB)) begin
          own = 2; streak = if_req ? streak + 1 : 0; busy_n = 0;
          m_req = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        end else if (if_ok) begin
          own = 1; streak = 0; busy_n = 0; kill_seen = 1'b0;
          m_req = 1; m_we = 0; m_addr = if_addr;
        end else if (!if_req) begin
          streak = 0;
        end
      end else if (own == 1 || own == 2) begin
        busy_n++;
        if (mem_ack) begin
          m_req = 0;
          if (own == 1) begin
            if (!kill_seen && !if_kill) begin
              m_if_done = 1; m_if_rdata = mem_rdata;
            end
          end else begin
            m_dm_done = 1;
            if (!m_we) m_dm_rdata = mem_rdata;
          end
          own = 0;
        end else begin
          if (own == 1 && if_kill) kill_seen = 1'b1;
          if (TO_EN && busy_n >= TO) begin
            own = 3; m_req = 0; m_err = 1;
          end
        end
      end
    end
  end

  // Compare DUT against the model just after every rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    chk("mem_req", mem_req, m_req);
    if (m_req) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_done", if_done, m_if_done);
    chk("dm_done", dm_done, m_dm_done);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("arb_err", arb_err, m_err);
    chk("if_stall", if_stall, if_req & ~m_if_done);
    chk("dm_stall", dm_stall, dm_req & ~m_dm_done);
  end

  task automatic wait_dm(input string nm, output int t);
    t = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (dm_done) begin t = cyc; break; end
    end
    if (t < 0) chk({nm, "_dm_done_timeout"}, 0, 1);
  endtask

  task automatic wait_if(input string nm, output int t);
    t = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (if_done) begin t = cyc; break; end
    end
    if (t < 0) chk({nm, "_if_done_timeout"}, 0, 1);
  endtask

  function automatic logic [31:0] log_at(input int k);
    return (glog.size() > k) ? glog[k] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int c0, t_dm, t_if, lq, n, nreq, ndone;
    logic [31:0] prev;
    logic [31:0] exp_seq[6];

    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous load and fetch: data first, fetch in the data done cycle.
    c0 = cyc; lq = glog.size();
    fork
      begin dm_we = 0; dm_addr = 32'h40; dm_req = 1; wait_dm("s1", t_dm); dm_req = 0; end
      begin if_addr = 32'h100; if_req = 1; wait_if("s1", t_if); if_req = 0; end
    join
    chk("s1_dm_done_cyc", t_dm - c0, 2);
    chk("s1_if_done_cyc", t_if - c0, 4);
    chk("s1_first_addr", log_at(lq), 32'h40);
    chk("s1_if_addr", log_at(lq + 1), 32'h100);
    chk("s1_if_req_cyc", ((gcyc.size() > lq + 1) ? gcyc[lq + 1] : -1) - c0, 3);
    chk("s1_dm_rdata", dm_rdata, 32'hC0DE_0040);
    chk("s1_if_rdata", if_rdata, 32'hC0DE_0100);
    @(negedge clk);

    // Data burst with a fetch pending (held off by kill during the done cycles).
    lq = glog.size();
    dm_we = 0; dm_addr = 32'h200; dm_req = 1;
    if_addr = 32'h300; if_req = 1; if_kill = 1;
    n = 0;
    for (int i = 0; i < 64 && n < 4; i++) begin
      @(negedge clk);
      if (dm_done) n++;
    end
    chk("s2_dm_done_cnt", n, 4);
    @(negedge clk);
    if_kill = 0;
    wait_if("s2", t_if); if_req = 0;
    wait_dm("s2", t_dm); dm_req = 0;
    exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300, 32'h200};
    chk("s2_grant_cnt", glog.size() - lq, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("s2_grant%0d", k), log_at(lq + k), exp_seq[k]);
    @(negedge clk);

    // Killed fetch with a slow memory: access completes, no done, rdata kept.
    prev = if_rdata; ack_delay = 2; nreq = 0; ndone = 0;
    if_addr = 32'h500; if_req = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      nreq += int'(mem_req); ndone += int'(if_done);
      if (i == 2) if_kill = 1;
      if (i == 3) begin if_kill = 0; if_req = 0; end
    end
    chk("s3_mem_req_cycles", nreq, 3);
    chk("s3_if_done_cnt", ndone, 0);
    chk("s3_if_rdata_kept", if_rdata, prev);
    chk("s3_prev_value", prev, 32'hC0DE_0300);

    // Store: write controls held until ack, load data untouched.
    prev = dm_rdata; nreq = 0; ndone = 0;
    dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF; dm_req = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        nreq++;
        chk("s4_mem_we", mem_we, 1);
        chk("s4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s4_mem_addr", mem_addr, 32'h80);
      end
      if (dm_done) begin ndone = 1; break; end
    end
    dm_req = 0; dm_we = 0;
    chk("s4_mem_req_cycles", nreq, 3);
    chk("s4_dm_done", ndone, 1);
    chk("s4_dm_rdata_kept", dm_rdata, 32'hC0DE_0200);
    ack_delay = 0;
    @(negedge clk);

    // Asynchronous reset in the middle of a data access.
    ack_delay = 5; lq = glog.size();
    dm_addr = 32'h60; dm_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("s5_busy_mem_req", mem_req, 1);
    #2;
    reset = 1'b1; dm_req = 0;
    #1;
    chk("s5_async_mem_req", mem_req, 0);
    chk("s5_async_mem_we", mem_we, 0);
    chk("s5_async_mem_addr", mem_addr, 0);
    chk("s5_async_dm_rdata", dm_rdata, 0);
    chk("s5_async_if_rdata", if_rdata, 0);
    chk("s5_async_dm_done", dm_done, 0);
    @(negedge clk);
    reset = 1'b0;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    chk("s5_no_replay_req", mem_req, 0);
    chk("s5_no_replay_log", glog.size() - lq, 1);
    if_addr = 32'h700; if_req = 1;
    wait_if("s5", t_if); if_req = 0;
    chk("s5_after_fetch", if_rdata, 32'hC0DE_0700);
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: error after TO busy cycles, then no more grants.
    no_ack = 1; nreq = 0; ndone = 0;
    dm_addr = 32'h90; dm_req = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      nreq += int'(mem_req); ndone += int'(dm_done);
      if (i == 15) begin if_addr = 32'h900; if_req = 1; end
    end
    chk("s6_busy_cycles", nreq, TO);
    chk("s6_no_done", ndone, 0);
    chk("s6_arb_err", arb_err, 1);
    dm_req = 0; if_req = 0; no_ack = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("s6_err_cleared", arb_err, 0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clk and reset as in the pipeline submodules.
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter DATA_W, 32, data width.
REQ-004 Parameter MAX_DM_BURST, 4, consecutive data grants allowed while a fetch waits.
REQ-005 Parameter TIMEOUT_CYCLES, 255, busy cycles without mem_ack before error; used only with ARB_TIMEOUT_EN.
REQ-006 Port clk, input, 1, rising-edge clock.
REQ-007 Port reset, input, 1, asynchronous active-high reset.
REQ-008 Port if_req / if_addr, input, 1 / ADDR_W, instruction-fetch read request and address.
REQ-009 Port if_kill, input, 1, fetch flush (branch KILL).
REQ-010 Port if_done / if_rdata, output, 1 / DATA_W, fetch completion pulse and instruction.
REQ-011 Port if_stall, output, 1, fetch waiting, wired to disable_PC/disable_IR.
REQ-012 Port dm_req / dm_we / dm_addr / dm_wdata, input, 1 / 1 / ADDR_W / DATA_W, data-stage request, write enable, address and store data.
REQ-013 Port dm_done / dm_rdata, output, 1 / DATA_W, data completion pulse and load data.
REQ-014 Port dm_stall, output, 1, data stage waiting.
REQ-015 Port mem_req / mem_we / mem_addr / mem_wdata, output, 1 / 1 / ADDR_W / DATA_W, single shared memory port.
REQ-016 Port mem_ack / mem_rdata, input, 1 / DATA_W, memory completion and read data.
REQ-017 Port arb_err, output, 1, sticky timeout error.

Function
REQ-018 FSM states SHALL be IDLE, BUSY_IF, BUSY_DM and ERR.
REQ-019 IDLE with dm_req eligible -> BUSY_DM; otherwise if_req eligible and if_kill low -> BUSY_IF; otherwise stay in IDLE.
REQ-020 Data SHALL have fixed priority, except after MAX_DM_BURST consecutive DM grants with if_req pending; then the next grant goes to IF and the burst counter clears.
REQ-021 The burst counter SHALL clear on any IF grant or whenever if_req is low in IDLE.
REQ-022 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered: captured at the grant edge and held constant in the BUSY state until mem_ack.
REQ-023 mem_we SHALL be 0 in BUSY_IF.
REQ-024 At the mem_ack edge in a BUSY state: go to IDLE, drop mem_req, pulse the owner's done for exactly one cycle, and register mem_rdata into the owner's rdata for loads and fetches.
REQ-025 Minimum transaction latency: request at cycle 0, mem_req at cycle 1, zero-wait ack at cycle 1, done at cycle 2.
REQ-026 Requesters SHALL hold req and operands until done; a requester is ineligible in the cycle its done is high, so no regrant occurs.
REQ-027 For stores, dm_done SHALL pulse and dm_rdata SHALL hold its previous value.
REQ-028 if_kill high in BUSY_IF or in the completing cycle SHALL let the memory access finish, suppress if_done and leave if_rdata unchanged.
REQ-029 if_stall SHALL equal if_req & ~if_done, and dm_stall SHALL equal dm_req & ~dm_done.
REQ-030 mem_ack in IDLE or ERR SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE asynchronously, including mid-transaction.
REQ-032 Reset SHALL force mem_req, mem_we, if_done, dm_done and arb_err to 0, clear all counters, and set mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
REQ-033 A transaction interrupted by reset SHALL NOT be replayed.

Configuration
REQ-034 With ARB_TIMEOUT_EN defined, a busy counter SHALL count cycles in BUSY states and clear on entry to a BUSY state.
REQ-035 With ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without mem_ack SHALL enter ERR: mem_req low, arb_err high, no done pulses, no further grants until reset.
REQ-036 Without ARB_TIMEOUT_EN, no counter SHALL exist, arb_err SHALL be tied 0, ERR SHALL be unreachable, and BUSY SHALL wait indefinitely.

Structure
REQ-037 Shared package mem_arb_pkg SHALL hold the FSM state typedef, the owner encoding (OWN_IF, OWN_DM) and the default parameter constants.
REQ-038 The watchdog SHALL be one sub-module, arb_timeout_cnt, instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-039 Scenario: dm_req load at 0x40 and if_req at 0x100 simultaneously, zero-wait ack -> DM granted first, dm_done at cycle 2; IF mem_req at cycle 3, if_done at cycle 4.
REQ-040 Scenario: dm_req held continuously with if_req pending -> exactly 4 DM grants, then 1 IF grant, then DM resumes.
REQ-041 Scenario: IF fetch with mem_ack delayed 3 cycles and if_kill pulsed in the 2nd busy cycle -> mem_req held 3 cycles, no if_done, if_rdata unchanged.
REQ-042 Scenario: store 0xDEADBEEF to 0x80 -> mem_we=1 and mem_wdata=0xDEADBEEF held until ack, dm_done pulses, dm_rdata unchanged.
REQ-043 Scenario: reset asserted in BUSY_DM -> mem_req=0 immediately with no clock edge, all outputs 0, IDLE after release.
REQ-044 Scenario (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): never ack -> arb_err=1 after 8 busy cycles and stays 1, no further mem_req.
